// File: rtl/fs3_load_sequencer_pkg.sv
// fs3_load_sequencer_pkg
//   Shared types and helpers for the bitplane load sequencer:
//   FSM state encoding, requester source encoding and the per-plane
//   bit-reverse used for horizontal flip.
package fs3_load_sequencer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Requester / word source encoding (also the PIX_SRC value).
    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    // Widest bank word the reverse helper handles (NPLANES*DEPTH).
    localparam int unsigned FS3_MAX_W = 128;

    // Bit-reverse each DEPTH-wide plane field of the low nplanes*depth bits;
    // bits above the word are returned as zero.
    function automatic logic [FS3_MAX_W-1:0] reverse_planes(
        input logic [FS3_MAX_W-1:0] data,
        input int unsigned          nplanes,
        input int unsigned          depth
    );
        logic [FS3_MAX_W-1:0] res;
        logic [FS3_MAX_W-1:0] one_bit;
        int unsigned          plane;
        int unsigned          pos;
        res = '0;
        for (int unsigned i = 0; i < FS3_MAX_W; i++) begin
            if (i < nplanes * depth) begin
                plane   = i / depth;
                pos     = i % depth;
                one_bit = (data >> i) & FS3_MAX_W'(1);
                res     = res | (one_bit << (plane * depth + depth - 1 - pos));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fs3_load_sequencer_if.sv
// fs3_load_sequencer_if
//   Bundles the two requester handshakes, the pixel-side flow control and
//   the shift-register bank controls of the load sequencer.
//   slave  : sequencer side (takes requests, drives bank controls)
//   master : environment side (requesters, downstream, bank)
interface fs3_load_sequencer_if #(
    parameter int unsigned NPLANES = 4,
    parameter int unsigned DEPTH   = 4
);
    import fs3_load_sequencer_pkg::*;

    localparam int unsigned W = NPLANES * DEPTH;

    // Requester A
    logic         A_VALID;
    logic [W-1:0] A_DATA;
    logic         A_FLIP;
    logic         A_READY;
    // Requester B
    logic         B_VALID;
    logic [W-1:0] B_DATA;
    logic         B_FLIP;
    logic         B_READY;
    // Downstream / control
    logic         PIX_READY;
    logic         FLUSH;
    // Bank controls and pixel qualifiers
    logic         nL;
    logic [W-1:0] P;
    logic         SH_EN;
    logic         PIX_VALID;
    logic         PIX_LAST;
    logic         PIX_SRC;

    modport slave (
        input  A_VALID, A_DATA, A_FLIP,
        output A_READY,
        input  B_VALID, B_DATA, B_FLIP,
        output B_READY,
        input  PIX_READY, FLUSH,
        output nL, P, SH_EN, PIX_VALID, PIX_LAST, PIX_SRC
    );

    modport master (
        output A_VALID, A_DATA, A_FLIP,
        input  A_READY,
        output B_VALID, B_DATA, B_FLIP,
        input  B_READY,
        output PIX_READY, FLUSH,
        input  nL, P, SH_EN, PIX_VALID, PIX_LAST, PIX_SRC
    );

endinterface

// File: rtl/fs3_rr_arbiter.sv
// fs3_rr_arbiter
//   Two-requester arbiter. Grants only while enable is high; with both
//   requesting it picks the requester other than the last winner when
//   rr=1, otherwise requester A (bit 0). The last winner is recorded
//   whenever a grant is issued (a grant always implies an accept, since
//   grants are only given to requesters that are valid).
//   clk, rst : clock, synchronous active-high reset (last winner -> B)
//   enable   : a load may happen this cycle
//   req[1:0] : {B_VALID, A_VALID}
//   rr       : 1 = round-robin, 0 = fixed priority A
//   gnt[1:0] : one-hot {B, A} grant
module fs3_rr_arbiter
    import fs3_load_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] req,
    input  logic       rr,
    output logic [1:0] gnt
);

    logic last_gnt_q;
    logic last_gnt_d;

    always_comb begin
        gnt        = '0;
        last_gnt_d = last_gnt_q;
        if (enable) begin
            if (req == 2'b01) begin
                gnt = 2'b01;
            end else if (req == 2'b10) begin
                gnt = 2'b10;
            end else if (req == 2'b11) begin
                gnt = (rr && (last_gnt_q == SRC_A)) ? 2'b10 : 2'b01;
            end
        end
        if (gnt[0]) begin
            last_gnt_d = SRC_A;
        end else if (gnt[1]) begin
            last_gnt_d = SRC_B;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt_q <= SRC_B;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

endmodule

// File: rtl/fs3_load_sequencer.sv
// fs3_load_sequencer
//   Load controller for a bank of NPLANES DEPTH-bit parallel-load shift
//   registers. Accepts tile words from requesters A/B, loads them (with
//   optional per-plane flip) through nL/P, shifts with SH_EN and qualifies
//   each bank output pixel with PIX_VALID/PIX_LAST/PIX_SRC. A new word is
//   loaded on the last pixel of the current one so words stream with no
//   bubble.
//   CK   : clock
//   RST  : synchronous active-high reset
//   bus  : requester handshakes, PIX_READY/FLUSH and bank controls
module fs3_load_sequencer
    import fs3_load_sequencer_pkg::*;
#(
    parameter int unsigned NPLANES = 4,
    parameter int unsigned DEPTH   = 4,
    parameter bit          RR      = 1'b1
)
(
    input  logic                 CK,
    input  logic                 RST,
    fs3_load_sequencer_if.slave  bus
);

    localparam int unsigned     W        = NPLANES * DEPTH;
    localparam int unsigned     CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEPTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          src_q, src_d;

    logic          cnt_last;
    logic          can_load;
    logic [1:0]    gnt;
    logic [W-1:0]  sel_data;
    logic          sel_flip;

    // Load opportunity: idle, or the last pixel of the word is consumed.
    // Reset and FLUSH both suppress any accept.
    always_comb begin
        cnt_last = (cnt_q == CNT_LAST);
        can_load = !RST && !bus.FLUSH &&
                   ((state_q == IDLE) ||
                    ((state_q == SHIFT) && cnt_last && bus.PIX_READY));
    end

    fs3_rr_arbiter u_arb (
        .clk    (CK),
        .rst    (RST),
        .enable (can_load),
        .req    ({bus.B_VALID, bus.A_VALID}),
        .rr     (RR),
        .gnt    (gnt)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        src_d         = src_q;
        bus.A_READY   = gnt[0];
        bus.B_READY   = gnt[1];
        bus.nL        = 1'b1;
        bus.P         = '0;
        bus.SH_EN     = 1'b0;
        bus.PIX_VALID = !RST && (state_q == SHIFT);
        bus.PIX_LAST  = !RST && (state_q == SHIFT) && cnt_last;
        bus.PIX_SRC   = src_q;

        sel_data = gnt[1] ? bus.B_DATA : bus.A_DATA;
        sel_flip = gnt[1] ? bus.B_FLIP : bus.A_FLIP;

        if (bus.FLUSH) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (|gnt) begin
            // Load wins over the shift on the last pixel: no SH_EN here.
            bus.nL  = 1'b0;
            bus.P   = sel_flip ?
                      W'(reverse_planes(FS3_MAX_W'(sel_data), NPLANES, DEPTH)) :
                      sel_data;
            state_d = SHIFT;
            cnt_d   = '0;
            src_d   = gnt[1] ? SRC_B : SRC_A;
        end else if ((state_q == SHIFT) && bus.PIX_READY && !RST) begin
            if (!cnt_last) begin
                bus.SH_EN = 1'b1;
                cnt_d     = cnt_q + CW'(1);
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= SRC_A;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

endmodule

// File: tb/tb_fs3_load_sequencer.sv
// tb_fs3_load_sequencer
//   Directed bench with a scoreboard: scenarios push the expected loads
//   and consumed pixels into queues; a negedge monitor pops and compares
//   each load (nL=0) and each consumed pixel (PIX_VALID && PIX_READY).
//   A second instance with fixed priority covers RR=0.
module tb_fs3_load_sequencer;
    import fs3_load_sequencer_pkg::*;

    logic CK = 1'b0;
    logic RST;
    always #5 CK = ~CK;

    fs3_load_sequencer_if #(.NPLANES(4), .DEPTH(4)) bus  ();
    fs3_load_sequencer_if #(.NPLANES(4), .DEPTH(4)) bus0 ();

    fs3_load_sequencer #(.NPLANES(4), .DEPTH(4), .RR(1'b1)) dut (
        .CK  (CK),
        .RST (RST),
        .bus (bus)
    );

    fs3_load_sequencer #(.NPLANES(4), .DEPTH(4), .RR(1'b0)) dut_fp (
        .CK  (CK),
        .RST (RST),
        .bus (bus0)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct packed {
        logic [15:0] p;
        logic        src;
    } load_t;

    typedef struct packed {
        logic src;
        logic last;
        logic sh;
        logic nl;
    } pix_t;

    load_t load_q[$];
    pix_t  pix_q[$];
    load_t le;
    pix_t  pe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, what);
    endtask

    // One word: load, three shifting pixels, then the last pixel which
    // carries the next load when the following word is chained.
    task automatic push_word(input logic [15:0] p, input logic src, input bit chained);
        load_q.push_back(load_t'({p, src}));
        for (int i = 0; i < 3; i++) pix_q.push_back(pix_t'({src, 1'b0, 1'b1, 1'b1}));
        pix_q.push_back(pix_t'({src, 1'b1, 1'b0, ~chained}));
    endtask

    always @(negedge CK) begin
        if (RST !== 1'b1) begin
            if (bus.nL === 1'b0) begin
                if (load_q.size() == 0) begin
                    fail_now("load_unexpected", $sformatf("P=%0h with no load expected", bus.P));
                end else begin
                    le = load_q.pop_front();
                    check("load_p", 32'(bus.P), 32'(le.p));
                    check("load_ready", 32'({bus.B_READY, bus.A_READY}),
                          le.src ? 32'h2 : 32'h1);
                end
            end
            if (bus.PIX_VALID === 1'b1 && bus.PIX_READY === 1'b1) begin
                if (pix_q.size() == 0) begin
                    fail_now("pix_unexpected", "pixel with none expected");
                end else begin
                    pe = pix_q.pop_front();
                    check("pix_src_last_sh_nl",
                          32'({bus.PIX_SRC, bus.PIX_LAST, bus.SH_EN, bus.nL}),
                          32'(pe));
                end
            end
        end
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Wait (bounded) for an accept, check who got it, return just after
    // the accepting edge.
    task automatic wait_accept(input string name, input logic want_b);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge CK);
            if (bus.A_READY === 1'b1 || bus.B_READY === 1'b1) begin
                got = 1'b1;
                check({name, "_who"}, 32'(bus.B_READY), 32'(want_b));
            end
        end
        if (!got) fail_now({name, "_timeout"}, "no accept within 40 cycles");
        step();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic idle_check(input string name);
        @(negedge CK);
        check(name, 32'(bus.PIX_VALID), 32'h0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        RST = 1'b1;
        bus.A_VALID = 1'b1; bus.A_DATA = 16'hFFFF; bus.A_FLIP = 1'b0;
        bus.B_VALID = 1'b1; bus.B_DATA = 16'hFFFF; bus.B_FLIP = 1'b0;
        bus.PIX_READY = 1'b1; bus.FLUSH = 1'b0;
        bus0.A_VALID = 1'b0; bus0.A_DATA = '0; bus0.A_FLIP = 1'b0;
        bus0.B_VALID = 1'b0; bus0.B_DATA = '0; bus0.B_FLIP = 1'b0;
        bus0.PIX_READY = 1'b1; bus0.FLUSH = 1'b0;
        #1;
        repeat (2) step();

        // Reset state with both requesters valid
        @(negedge CK);
        check("rst_a_ready", 32'(bus.A_READY), 32'h0);
        check("rst_b_ready", 32'(bus.B_READY), 32'h0);
        check("rst_nl", 32'(bus.nL), 32'h1);
        check("rst_sh_en", 32'(bus.SH_EN), 32'h0);
        check("rst_pix_valid", 32'(bus.PIX_VALID), 32'h0);
        check("rst_pix_last", 32'(bus.PIX_LAST), 32'h0);
        step();
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0; RST = 1'b0;
        idle_check("idle_after_rst");

        // Single word from A, no flip
        push_word(16'hA5C3, SRC_A, 1'b0);
        bus.A_DATA = 16'hA5C3; bus.A_FLIP = 1'b0; bus.A_VALID = 1'b1;
        wait_accept("s1", 1'b0);
        bus.A_VALID = 1'b0;
        repeat (4) step();
        idle_check("s1_idle");

        // Flip: per-plane reversal of A5C3 is 5A3C
        push_word(16'h5A3C, SRC_A, 1'b0);
        bus.A_FLIP = 1'b1; bus.A_VALID = 1'b1;
        wait_accept("s2", 1'b0);
        bus.A_VALID = 1'b0; bus.A_FLIP = 1'b0;
        repeat (4) step();
        idle_check("s2_idle");

        // Round-robin stream, both held valid; flipped BEEF is D77F
        do_reset();
        push_word(16'h1234, SRC_A, 1'b1);
        push_word(16'hD77F, SRC_B, 1'b1);
        push_word(16'h1234, SRC_A, 1'b1);
        push_word(16'hD77F, SRC_B, 1'b0);
        bus.A_DATA = 16'h1234; bus.A_FLIP = 1'b0; bus.A_VALID = 1'b1;
        bus.B_DATA = 16'hBEEF; bus.B_FLIP = 1'b1; bus.B_VALID = 1'b1;
        acc = 0;
        for (int i = 0; i < 40 && acc < 4; i++) begin
            @(negedge CK);
            if (acc > 0) check("s3_no_bubble", 32'(bus.PIX_VALID), 32'h1);
            if (bus.A_READY === 1'b1 || bus.B_READY === 1'b1) acc++;
            step();
        end
        check("s3_accepts", 32'(acc), 32'h4);
        bus.A_VALID = 1'b0; bus.B_VALID = 1'b0; bus.B_FLIP = 1'b0;
        repeat (4) step();
        idle_check("s3_idle");

        // Fixed priority instance: A always, B never
        bus0.A_DATA = 16'h1234; bus0.A_VALID = 1'b1;
        bus0.B_DATA = 16'h9999; bus0.B_VALID = 1'b1;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CK);
            check("s4_b_ready", 32'(bus0.B_READY), 32'h0);
            if (bus0.nL === 1'b0) check("s4_load_p", 32'(bus0.P), 32'h1234);
            if (bus0.A_READY === 1'b1) acc++;
            step();
        end
        check("s4_a_grants", 32'(acc), 32'h4);
        bus0.A_VALID = 1'b0; bus0.B_VALID = 1'b0;

        // Stall 3 cycles at CNT=1 with A valid
        push_word(16'h0F0F, SRC_A, 1'b1);
        push_word(16'h3C3C, SRC_A, 1'b0);
        bus.A_DATA = 16'h0F0F; bus.A_VALID = 1'b1;
        wait_accept("s5a", 1'b0);
        bus.A_DATA = 16'h3C3C;
        step();
        bus.PIX_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CK);
            check("s5_stall_sh_en", 32'(bus.SH_EN), 32'h0);
            check("s5_stall_a_ready", 32'(bus.A_READY), 32'h0);
            check("s5_stall_nl", 32'(bus.nL), 32'h1);
            check("s5_stall_pix_valid", 32'(bus.PIX_VALID), 32'h1);
            step();
        end
        bus.PIX_READY = 1'b1;
        wait_accept("s5b", 1'b0);
        bus.A_VALID = 1'b0;
        repeat (4) step();
        idle_check("s5_idle");

        // FLUSH at CNT=2 with B pending
        load_q.push_back(load_t'({16'h1111, SRC_A}));
        pix_q.push_back(pix_t'({SRC_A, 1'b0, 1'b1, 1'b1}));
        pix_q.push_back(pix_t'({SRC_A, 1'b0, 1'b1, 1'b1}));
        pix_q.push_back(pix_t'({SRC_A, 1'b0, 1'b0, 1'b1}));
        push_word(16'h2222, SRC_B, 1'b0);
        bus.A_DATA = 16'h1111; bus.A_VALID = 1'b1;
        wait_accept("s6a", 1'b0);
        bus.A_VALID = 1'b0;
        bus.B_DATA = 16'h2222; bus.B_FLIP = 1'b0; bus.B_VALID = 1'b1;
        step();
        step();
        bus.FLUSH = 1'b1;
        @(negedge CK);
        check("s6_flush_b_ready", 32'(bus.B_READY), 32'h0);
        check("s6_flush_pix_valid", 32'(bus.PIX_VALID), 32'h1);
        step();
        bus.FLUSH = 1'b0;
        @(negedge CK);
        check("s6_after_pix_valid", 32'(bus.PIX_VALID), 32'h0);
        check("s6_after_b_ready", 32'(bus.B_READY), 32'h1);
        step();
        bus.B_VALID = 1'b0;
        repeat (4) step();
        idle_check("s6_idle");

        // RST at CNT=1; A was last winner, reset makes A win again
        load_q.push_back(load_t'({16'h4444, SRC_A}));
        pix_q.push_back(pix_t'({SRC_A, 1'b0, 1'b1, 1'b1}));
        bus.A_DATA = 16'h4444; bus.A_VALID = 1'b1;
        wait_accept("s7a", 1'b0);
        bus.A_VALID = 1'b0;
        step();
        RST = 1'b1; bus.A_VALID = 1'b1; bus.B_VALID = 1'b1;
        @(negedge CK);
        check("s7_rst_a_ready", 32'(bus.A_READY), 32'h0);
        check("s7_rst_b_ready", 32'(bus.B_READY), 32'h0);
        check("s7_rst_nl", 32'(bus.nL), 32'h1);
        check("s7_rst_sh_en", 32'(bus.SH_EN), 32'h0);
        step();
        RST = 1'b0; bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
        @(negedge CK);
        check("s7_post_nl", 32'(bus.nL), 32'h1);
        check("s7_post_sh_en", 32'(bus.SH_EN), 32'h0);
        check("s7_post_pix_valid", 32'(bus.PIX_VALID), 32'h0);
        check("s7_post_pix_last", 32'(bus.PIX_LAST), 32'h0);
        step();
        push_word(16'h5555, SRC_A, 1'b1);
        push_word(16'h6666, SRC_B, 1'b0);
        bus.A_DATA = 16'h5555; bus.A_VALID = 1'b1;
        bus.B_DATA = 16'h6666; bus.B_FLIP = 1'b0; bus.B_VALID = 1'b1;
        wait_accept("s7_first", 1'b0);
        bus.A_VALID = 1'b0;
        wait_accept("s7_second", 1'b1);
        bus.B_VALID = 1'b0;
        repeat (4) step();
        idle_check("s7_idle");

        repeat (3) step();
        check("drain_loads", 32'(load_q.size()), 32'h0);
        check("drain_pixels", 32'(pix_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
